// File: rtl/prog_loader_pkg.sv
// Shared definitions for the byte-stream program loader: state encodings,
// error codes and the default frame sync marker.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Program loader: parses SYNC/LEN/data/CHK frames from a byte stream, writes
// the data into RAM and keeps the CPU in reset until a frame verifies.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  SYNC_BYTE  = DATA_WIDTH'(DEF_SYNC_BYTE),
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
    parameter int unsigned            TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_write_en,
    output logic                  cpu_hold,
    output logic                  done,
    output logic [1:0]            err
);

    localparam int unsigned REM_W  = DATA_WIDTH + 1;
    localparam int unsigned IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    loader_state_t         state, state_nxt;
    logic [REM_W-1:0]      remaining, remaining_nxt;
    logic [DATA_WIDTH-1:0] sum, sum_nxt;
    logic [ADDR_WIDTH-1:0] addr, addr_nxt;
    logic [IDLE_W-1:0]     idle_cnt;

    logic                  wr_en_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [DATA_WIDTH-1:0] wr_data_nxt;
    logic                  hold_nxt;
    logic                  done_nxt;
    logic [1:0]            err_nxt;

    logic                  accept;
    logic                  in_frame;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] chk_sum;

    // The loader never back-pressures the stream.
    assign rx_ready    = 1'b1;
    assign accept      = rx_valid;
    assign in_frame    = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
    assign timeout_hit = in_frame && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 2));
    assign chk_sum     = sum + rx_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        sum_nxt       = sum;
        addr_nxt      = addr;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = ram_addr;
        wr_data_nxt   = ram_data;
        hold_nxt      = cpu_hold;
        done_nxt      = done;
        err_nxt       = err;

        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_nxt = ST_LEN;
                    hold_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    err_nxt   = ERR_NONE;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    // A zero length byte encodes a full 2^DATA_WIDTH image.
                    remaining_nxt = (rx_data == '0) ? (REM_W'(1) << DATA_WIDTH)
                                                    : REM_W'(rx_data);
                    sum_nxt       = '0;
                    addr_nxt      = BASE_ADDR;
                    state_nxt     = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr_en_nxt     = 1'b1;
                    wr_addr_nxt   = addr;
                    wr_data_nxt   = rx_data;
                    sum_nxt       = chk_sum;
                    addr_nxt      = addr + ADDR_WIDTH'(1);
                    remaining_nxt = remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (chk_sum == '0) begin
                        state_nxt = ST_DONE;
                        hold_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_CHK;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (timeout_hit) begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_TIMEOUT;
            hold_nxt  = 1'b1;
            done_nxt  = 1'b0;
        end
    end

    // Frame datapath and registered RAM/CPU-control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining    <= '0;
            sum          <= '0;
            addr         <= BASE_ADDR;
            ram_write_en <= 1'b0;
            ram_addr     <= BASE_ADDR;
            ram_data     <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= ERR_NONE;
        end else begin
            remaining    <= remaining_nxt;
            sum          <= sum_nxt;
            addr         <= addr_nxt;
            ram_write_en <= wr_en_nxt;
            ram_addr     <= wr_addr_nxt;
            ram_data     <= wr_data_nxt;
            cpu_hold     <= hold_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

    // Inter-byte idle counter, only live while a frame is in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                idle_cnt <= '0;
        else if (!in_frame || accept || timeout_hit) idle_cnt <= '0;
        else                                       idle_cnt <= idle_cnt + IDLE_W'(1);
    end

endmodule
